str_to_integer: RTL
===================

Name: str_to_integer

Overview:
Sequential ASCII-decimal-to-binary parser: the inverse of the integer-to-string formatter on the debug UART path. Takes a received command string from the UART receive buffer, consumes it one character per clock, most significant digit first, and returns an unsigned binary value with status flags. Sits between the UART data_i bus and the gate-pool control logic, so numeric operands can be typed from the PC.

Parameters:
WIDTH, 32, bit width of the result value.
MAX_DIGITS, 10, maximum characters examined; also the input string width in bytes.
NDW, 4, width of the digit-count output; must satisfy 2^NDW > MAX_DIGITS.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
i_str  in  MAX_DIGITS*8  input string; byte 0 = bits [7:0] = first received character = most significant digit.
i_start  in  1  request to parse i_str; accepted only while o_ready=1.
o_ready  out  1  high in IDLE; start is accepted on a clock edge where i_start=1 and o_ready=1.
o_valid  out  1  one-cycle pulse; the result outputs are valid in this cycle.
o_value  out  WIDTH  parsed unsigned value; saturates at all-ones on overflow.
o_ndigits  out  NDW  number of digit characters consumed.
o_err  out  1  a non-digit, non-terminator character was encountered.
o_ovf  out  1  value exceeded 2^WIDTH-1.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; o_ready=1; o_valid=0; o_value=0; o_ndigits=0; o_err=0; o_ovf=0; internal index, accumulator and string register cleared.
- FSM states: IDLE, PARSE, DONE.
- IDLE: o_ready=1. On i_start, at that edge:
  - capture i_str into an internal register;
  - clear acc, idx, o_ndigits, o_err and o_ovf;
  - go to PARSE.
  - Without i_start, o_value and the flags hold their last result.
- PARSE: o_ready=0. Each edge examines captured byte b=str[idx]:
  - Terminator (0x00, 0x0D or 0x0A): go to DONE; acc unchanged.
  - Digit (0x30..0x39): acc = acc*10 + (b-0x30), computed in WIDTH+4 bits.
    - If the result exceeds 2^WIDTH-1, set o_ovf (sticky) and clamp acc to all-ones.
    - Once o_ovf is set, further digits keep acc at all-ones.
    - o_ndigits increments and idx increments.
    - If idx was MAX_DIGITS-1, go to DONE.
  - Any other byte: set o_err, go to DONE; acc keeps its value from the digits already consumed.
- DONE: o_valid=1 for exactly this one cycle; o_value = acc. Next edge goes to IDLE.
- Latency, start edge to o_valid high:
  - terminated string with k digits: k+1 edges;
  - string of MAX_DIGITS digits with no terminator: MAX_DIGITS edges.
- i_start while o_ready=0 is ignored and not queued. i_str may change freely after the start edge.
- i_start in the same cycle as o_valid is ignored (o_ready=0 in DONE). The earliest restart is the cycle after the pulse.
- Empty string (byte 0 is a terminator): o_valid after 1 edge, with o_value=0, o_ndigits=0 and no flags set.
- Leading zeros are accepted as digits ("007" gives 7, o_ndigits=3).
- Reset asserted mid-PARSE aborts with no o_valid pulse; the bench must not expect a result.

Decomposition:
- Shared package:
  - ASCII constants: ASCII_ZERO=8'h30, ASCII_NINE=8'h39, ASCII_NUL=8'h00, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - FSM state enum;
  - a "multiply by 10 = (x<<3)+(x<<1)" helper function.
- One combinational sub-module, ascii_digit_decode: byte in; is_digit, is_term and a 4-bit digit value out. Reused later by other command parsers on the UART path.

Test Plan:
- "123\0" in bytes 0..3, start -> o_valid on the 4th edge after start; o_value=123, o_ndigits=3, o_err=0, o_ovf=0.
- "4294967295" (10 digits, no terminator) -> o_valid after 10 edges; o_value=32'hFFFFFFFF, o_ovf=0. Then "4294967296" -> o_value=32'hFFFFFFFF, o_ovf=1.
- "12a4" -> o_valid after 3 edges; o_value=12, o_ndigits=2, o_err=1.
- "\r" (0x0D at byte 0) -> o_valid after 1 edge; o_value=0, o_ndigits=0, no flags.
- Pulse i_start again mid-PARSE on "98765\n" -> the second start is ignored and a single o_valid is produced with o_value=98765. Back-to-back: start "5\0" in the cycle after the pulse -> accepted, o_value=5.
- Assert rst during PARSE of "55555\0" -> o_ready=1 and all outputs 0 immediately, with no o_valid. A subsequent start on "42\0" -> o_value=42.

Source files
------------

// File: rtl/str_to_integer_pkg.sv
// Shared definitions for the ASCII decimal parser: character codes,
// FSM state type and the multiply-by-ten helper.
package str_to_integer_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_NUL  = 8'h00;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Width of the mul10 helper's operand; callers size down with a cast.
    localparam int unsigned MUL10_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARSE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // x*10 built from two shifts and an add.
    function automatic logic [MUL10_W-1:0] mul10(input logic [MUL10_W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

endpackage

// File: rtl/str_to_integer_ascii_digit_decode.sv
// Classifies one ASCII byte as decimal digit or line terminator and
// returns the digit value.
module ascii_digit_decode
    import str_to_integer_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_digit_o,
    output logic       is_term_o,
    output logic [3:0] digit_o
);

    // Pure decode of the byte; digit value is the low nibble for '0'..'9'.
    always_comb begin
        is_digit_o = (byte_i >= ASCII_ZERO) && (byte_i <= ASCII_NINE);
        is_term_o  = (byte_i == ASCII_NUL) || (byte_i == ASCII_CR) ||
                     (byte_i == ASCII_LF);
        digit_o    = is_digit_o ? byte_i[3:0] : '0;
    end

endmodule

// File: rtl/str_to_integer.sv
// Sequential ASCII-decimal to binary parser. Consumes the captured string
// one byte per clock, most significant digit first, and reports the value
// with digit count, error and saturation flags.
module str_to_integer
    import str_to_integer_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_DIGITS = 10,
    parameter int unsigned NDW        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MAX_DIGITS*8-1:0] i_str,
    input  logic                    i_start,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_value,
    output logic [NDW-1:0]          o_ndigits,
    output logic                    o_err,
    output logic                    o_ovf
);

    localparam int unsigned IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_DIGITS - 1);

    state_t                        state_q;
    logic [MAX_DIGITS-1:0][7:0]    str_q;
    logic [IW-1:0]                 idx_q;
    logic [WIDTH-1:0]              acc_q;
    logic [WIDTH-1:0]              acc_d;
    logic                          ovf_d;
    logic                          ready_q;
    logic                          valid_q;
    logic [WIDTH-1:0]              value_q;
    logic [NDW-1:0]                ndig_q;
    logic                          err_q;
    logic                          ovf_q;

    logic [7:0]                    cur_byte;
    logic                          is_digit;
    logic                          is_term;
    logic [3:0]                    digit;
    logic [MUL10_W-1:0]            wide;
    logic [WIDTH+3:0]              prod;

    assign cur_byte = str_q[idx_q];

    ascii_digit_decode u_decode (
        .byte_i     (cur_byte),
        .is_digit_o (is_digit),
        .is_term_o  (is_term),
        .digit_o    (digit)
    );

    // Next accumulator: acc*10 + digit in WIDTH+4 bits, saturating once
    // anything lands above WIDTH bits; overflow stays sticky.
    always_comb begin
        wide  = mul10(MUL10_W'(acc_q)) + MUL10_W'(digit);
        prod  = (WIDTH + 4)'(wide);
        ovf_d = ovf_q | (|prod[WIDTH+3:WIDTH]);
        acc_d = ovf_d ? '1 : prod[WIDTH-1:0];
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            str_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            value_q <= '0;
            ndig_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        str_q   <= i_str;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        ndig_q  <= '0;
                        err_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_PARSE;
                    end
                end
                ST_PARSE: begin
                    if (is_term) begin
                        value_q <= acc_q;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (is_digit) begin
                        acc_q  <= acc_d;
                        ovf_q  <= ovf_d;
                        ndig_q <= ndig_q + NDW'(1);
                        idx_q  <= idx_q + IW'(1);
                        // A full-width string finishes on its last digit,
                        // so the result is taken from acc_d, not acc_q.
                        if (idx_q == LAST_IDX) begin
                            value_q <= acc_d;
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        err_q   <= 1'b1;
                        value_q <= acc_q;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_value   = value_q;
    assign o_ndigits = ndig_q;
    assign o_err     = err_q;
    assign o_ovf     = ovf_q;

endmodule
